uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter between N_REQ byte sources (hex-display responder,
//  loopback echo, button-triggered messages). Round-robin arbitration with packet lock:
//  the granted source owns the TX until its byte flagged last has been sent.
//  Sits between requesters and the UART TX core: drives tx_start/tx_data, waits for tx_done.
// PARAMETERS
//  N_REQ       2        number of requesters (>=2)
//  DATA_W      8        byte width on every requester port and on tx_data
//  TIMEOUT_CYC 200000   max cycles in WAIT (no tx_done) or HOLD (no next byte) before abort
// PORTS
//  clk          in   1              system clock, all logic rising-edge
//  rst          in   1              asynchronous, active-low reset
//  req_valid    in   N_REQ          requester i has a byte on req_data[i]
//  req_data     in   N_REQ*DATA_W   byte of requester i at [i*DATA_W +: DATA_W]
//  req_last     in   N_REQ          byte of requester i ends its packet
//  req_ready    out  N_REQ          one-hot pulse: byte of requester i accepted this cycle
//  tx_start     out  1              1-cycle pulse to UART TX: send tx_data
//  tx_data      out  DATA_W         byte to transmit, stable from tx_start until next accept
//  tx_done      in   1              1-cycle pulse from UART TX: stop bit finished
//  grant_id     out  $clog2(N_REQ)  current/last owner of the TX
//  busy         out  1              1 in every state except IDLE
//  timeout_err  out  1              1-cycle pulse when a packet is aborted by timeout
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, rr_ptr=0, grant_id=0, tx_data=0, req_ready=0,
//   tx_start=0, busy=0, timeout_err=0, timer=0, last_q=0. Reset mid-packet drops it silently.
//  States: IDLE, SEND, WAIT, HOLD.
//  IDLE: winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
//   If any valid: req_ready[winner]=1 same cycle (combinational), register tx_data,
//   last_q=req_last[winner], grant_id=winner -> SEND. Else stay, req_ready=0.
//  SEND: tx_start=1 for exactly this cycle -> WAIT, timer cleared.
//  WAIT: timer++ each cycle. tx_done=1: last_q=1 -> IDLE, rr_ptr=(grant_id+1) mod N_REQ;
//   last_q=0 -> HOLD, timer cleared. timer reaches TIMEOUT_CYC-1 without tx_done:
//   timeout_err pulse, rr_ptr=(grant_id+1) mod N_REQ -> IDLE.
//  HOLD: only requester grant_id is served; other valids ignored. req_valid[grant_id]=1:
//   req_ready[grant_id]=1 same cycle, latch data/last -> SEND. Timer expiry: as in WAIT.
//  tx_done is sampled only in WAIT; pulses in IDLE/SEND/HOLD are ignored.
//  Byte-to-byte latency: accept cycle, SEND cycle, then WAIT; tx_start 1 cycle after accept.
//  Back-to-back packets from one source: after last byte it returns to IDLE and rr_ptr has
//   advanced, so any other pending source wins the next arbitration.
//  req_ready is never asserted in SEND or WAIT; at most one bit of req_ready is set.
//  rr_ptr wraps N_REQ-1 -> 0; timer width $clog2(TIMEOUT_CYC)+1, saturates never (reset on exit).
// TESTING
//  1 Single: req0 sends 0x41 last=1 -> req_ready[0] pulse, tx_start 1 cycle later, tx_data=0x41;
//    tx_done -> IDLE, busy=0, rr_ptr=1.
//  2 Fairness: req0,req1 both valid continuously, 1-byte packets -> TX order 0,1,0,1.
//  3 Packet lock: req0 sends 0x30,0x31,0x32(last) while req1 valid -> all three req0 bytes
//    sent before any req1 byte; req_ready[1] stays 0 during HOLD.
//  4 Timeout: tx_done never returned -> timeout_err pulse exactly TIMEOUT_CYC cycles after
//    entering WAIT, state IDLE, next requester granted; repeat with stalled HOLD.
//  5 Spurious tx_done in IDLE/SEND -> no state change, no extra req_ready.
//  6 rst low during WAIT of multi-byte packet -> all outputs 0 immediately; after release
//    a fresh req1 byte is accepted normally, rr_ptr=0 scan order.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-TX-side handshake bundle for uart_tx_arbiter.
// master: the environment (byte sources and UART TX core); slave: the arbiter.
interface uart_tx_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    tx_start;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_done;

    modport master (
        output req_valid, req_data, req_last, tx_done,
        input  req_ready, tx_start, tx_data
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_done,
        output req_ready, tx_start, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte sources.
// A granted source keeps the transmitter until its byte flagged last has been sent,
// or until a WAIT/HOLD stall exceeds TIMEOUT_CYC cycles and the packet is aborted.
module uart_tx_arbiter #(
    parameter  int N_REQ       = 2,
    parameter  int DATA_W      = 8,
    parameter  int TIMEOUT_CYC = 200000,
    localparam int GW          = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_arbiter_if.slave     bus,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic                 timeout_err
);
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_HOLD} state_t;

    state_t            state, state_next;
    logic [GW-1:0]     rr_ptr, winner, sel, next_ptr;
    logic              found, accept, adv_ptr, timeout_hit, expire;
    logic [N_REQ-1:0]  ready_vec;
    logic [DATA_W-1:0] tx_data_q, sel_data;
    logic              sel_last, last_q;
    logic [TW-1:0]     timer;

    // Pick the first valid requester scanning rr_ptr, rr_ptr+1, ... (lowest offset wins)
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                winner = GW'((int'(rr_ptr) + k) % N_REQ);
                found  = 1'b1;
            end
        end
    end

    // Next state, accept strobe and timeout decision
    always_comb begin
        state_next  = state;
        ready_vec   = '0;
        accept      = 1'b0;
        sel         = winner;
        adv_ptr     = 1'b0;
        timeout_hit = 1'b0;
        expire      = (timer == TW'(TIMEOUT_CYC - 1));
        unique case (state)
            ST_IDLE: begin
                if (found) begin
                    ready_vec[winner] = 1'b1;
                    accept            = 1'b1;
                    state_next        = ST_SEND;
                end
            end
            ST_SEND: state_next = ST_WAIT;
            ST_WAIT: begin
                if (bus.tx_done) begin
                    if (last_q) begin
                        adv_ptr    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_HOLD;
                    end
                end else if (expire) begin
                    timeout_hit = 1'b1;
                    adv_ptr     = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_HOLD: begin
                // Only the current owner may continue its packet
                sel = grant_id;
                if (bus.req_valid[grant_id]) begin
                    ready_vec[grant_id] = 1'b1;
                    accept              = 1'b1;
                    state_next          = ST_SEND;
                end else if (expire) begin
                    timeout_hit = 1'b1;
                    adv_ptr     = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Byte and last flag of the selected requester, plus the pointer after the owner
    always_comb begin
        sel_data = bus.req_data[int'(sel) * DATA_W +: DATA_W];
        sel_last = bus.req_last[sel];
        next_ptr = (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end

    // State, ownership, captured byte and stall timer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            tx_data_q   <= '0;
            last_q      <= 1'b0;
            timer       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            timeout_err <= timeout_hit;
            if (accept) begin
                grant_id  <= sel;
                tx_data_q <= sel_data;
                last_q    <= sel_last;
            end
            if (adv_ptr) begin
                rr_ptr <= next_ptr;
            end
            // Timer runs only while staying in WAIT or HOLD; any transition restarts it
            if ((state == ST_WAIT || state == ST_HOLD) && state_next == state) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end
        end
    end

    // Outputs; req_ready is held low while reset is asserted
    always_comb begin
        bus.req_ready = rst ? ready_vec : '0;
        bus.tx_start  = (state == ST_SEND);
        bus.tx_data   = tx_data_q;
        busy          = (state != ST_IDLE);
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued byte sources, a UART responder with random
// tx_done delay, and a packet-level round-robin model of the expected TX order.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int N  = 2;
    localparam int DW = 8;
    localparam int T  = 24;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [0:0]        grant_id;
    logic              busy;
    logic              timeout_err;

    uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_CYC(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Shared bench state
    ent_t        rq[N][$];
    int          head[N];
    int          cnt = 0;
    logic [15:0] tx_log[$];
    logic [15:0] exp_log[$];
    int          m_rr = 0;
    // written by the monitor
    int          acc_seq = 0, acc_idx = 0, start_seq = 0, start_cyc = 0;
    int          tout_seq = 0, tout_cyc = 0;
    logic [N-1:0] tout_rr;
    logic        tout_busy;
    // written by the environment driver
    int          cd = 0, done_cyc = 0;
    bit          mid[N];
    // written by the main sequence
    bit          mute = 0, rnd_stall = 0;
    bit          hold_stall[N];
    int          man_seq = 0, flush_seq = 0;

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (head[i] < rq[i].size()) return 1'b0;
        return 1'b1;
    endfunction

    // Environment: byte sources and UART responder, driven just after the rising edge
    initial begin
        int acc_done = 0, start_done = 0, man_done = 0, flush_done = 0;
        logic [N-1:0]    v, l;
        logic [N*DW-1:0] d;
        bit st;
        for (int i = 0; i < N; i++) head[i] = 0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.tx_done   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cnt++;
            if (!rst) begin
                cd = 0;
                for (int i = 0; i < N; i++) mid[i] = 1'b0;
                acc_done   = acc_seq;
                start_done = start_seq;
            end
            if (acc_seq != acc_done) begin
                acc_done = acc_seq;
                if (head[acc_idx] < rq[acc_idx].size()) begin
                    mid[acc_idx] = !rq[acc_idx][head[acc_idx]].l;
                    head[acc_idx]++;
                end
            end
            if (flush_seq != flush_done) begin
                flush_done = flush_seq;
                for (int i = 0; i < N; i++) begin
                    head[i] = rq[i].size();
                    mid[i]  = 1'b0;
                end
            end
            if (start_seq != start_done) begin
                start_done = start_seq;
                if (!mute) cd = $urandom_range(1, 6);
            end
            bus.tx_done = 1'b0;
            if (man_seq != man_done) begin
                man_done    = man_seq;
                bus.tx_done = 1'b1;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) bus.tx_done = 1'b1;
            end
            if (bus.tx_done) done_cyc = cnt;
            v = '0; l = '0; d = '0;
            for (int i = 0; i < N; i++) begin
                st = mid[i] && (hold_stall[i] || (rnd_stall && $urandom_range(0, 3) == 0));
                if (head[i] < rq[i].size() && !st) begin
                    v[i]            = 1'b1;
                    l[i]            = rq[i][head[i]].l;
                    d[i*DW +: DW]   = rq[i][head[i]].d;
                end
            end
            bus.req_valid = v;
            bus.req_last  = l;
            bus.req_data  = d;
        end
    end

    // Monitor: per-cycle protocol rules and TX log, sampled on the falling edge
    initial begin
        bit   pend = 0, locked = 0;
        int   pend_i = 0, owner = 0;
        logic [7:0] pend_d = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend   = 1'b0;
                locked = 1'b0;
            end else begin
                if (timeout_err) begin
                    tout_seq++;
                    tout_cyc  = cnt;
                    tout_rr   = bus.req_ready;
                    tout_busy = busy;
                    locked    = 1'b0;
                end
                if (pend) begin
                    check_eq("start_lat", bus.tx_start, 1);
                    check_eq("start_data", bus.tx_data, pend_d);
                    check_eq("grant", grant_id, pend_i);
                    pend = 1'b0;
                end else begin
                    check_eq("no_start", bus.tx_start, 0);
                end
                if (bus.tx_start) begin
                    tx_log.push_back({8'(grant_id), bus.tx_data});
                    start_seq++;
                    start_cyc = cnt;
                end
                if (bus.req_ready != '0) begin
                    check_eq("ready_1hot", $countones(bus.req_ready), 1);
                    check_eq("ready_in_send", bus.tx_start, 0);
                    if (locked) check_eq("lock", bus.req_ready, 1 << owner);
                    for (int i = 0; i < N; i++) begin
                        if (bus.req_ready[i]) begin
                            check_eq("ready_valid", bus.req_valid[i], 1);
                            if (head[i] < rq[i].size()) begin
                                pend   = 1'b1;
                                pend_i = i;
                                pend_d = rq[i][head[i]].d;
                                owner  = i;
                                locked = !rq[i][head[i]].l;
                            end
                            acc_idx = i;
                            acc_seq++;
                        end
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input int i, input logic [7:0] d, input bit l);
        ent_t e;
        e.d = d;
        e.l = l;
        rq[i].push_back(e);
    endtask

    // Packet-level round robin: whole packets, first non-empty source from m_rr
    task automatic build_expect();
        int pos[N];
        int w;
        bit done;
        for (int i = 0; i < N; i++) pos[i] = head[i];
        forever begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && pos[(m_rr + k) % N] < rq[(m_rr + k) % N].size()) w = (m_rr + k) % N;
            end
            if (w < 0) break;
            done = 1'b0;
            while (!done && pos[w] < rq[w].size()) begin
                exp_log.push_back({8'(w), rq[w][pos[w]].d});
                done = rq[w][pos[w]].l;
                pos[w]++;
            end
            m_rr = (w + 1) % N;
        end
    endtask

    task automatic drain(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            step(1);
            if (all_empty() && !busy && cd == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq({tag, "_drain"}, ok, 1);
        check_eq({tag, "_count"}, tx_log.size(), exp_log.size());
        for (int k = 0; k < exp_log.size() && k < tx_log.size(); k++)
            check_eq({tag, "_tx"}, tx_log[k], exp_log[k]);
        tx_log.delete();
        exp_log.delete();
    endtask

    task automatic wait_tout(input string tag, input int bound);
        int s0 = tout_seq;
        for (int k = 0; k < bound; k++) begin
            step(1);
            if (tout_seq != s0) break;
        end
        check_eq({tag, "_seen"}, (tout_seq != s0), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, a0, sc, np, nb;
        bit seen;
        step(3);
        check_eq("rst_grant", grant_id, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_start", bus.tx_start, 0);
        check_eq("rst_ready", bus.req_ready, 0);
        check_eq("rst_tout", timeout_err, 0);
        check_eq("rst_data", bus.tx_data, 0);
        rst = 1'b1;
        step(2);

        // single byte
        push(0, 8'h41, 1'b1);
        build_expect();
        drain("single");
        check_eq("single_busy", busy, 0);

        // fairness with one-byte packets, pointer now past source 0
        push(0, 8'hA0, 1'b1); push(0, 8'hA1, 1'b1);
        push(1, 8'hB0, 1'b1); push(1, 8'hB1, 1'b1); push(1, 8'hB2, 1'b1);
        build_expect();
        drain("fair");

        // packet lock with a competing source
        push(0, 8'h30, 1'b0); push(0, 8'h31, 1'b0); push(0, 8'h32, 1'b1);
        push(1, 8'h50, 1'b1);
        build_expect();
        drain("lock");

        // timeout in WAIT
        mute = 1'b1;
        push(0, 8'h60, 1'b1);
        push(1, 8'h70, 1'b1);
        exp_log.push_back({8'd0, 8'h60});
        exp_log.push_back({8'd1, 8'h70});
        s0 = start_seq;
        for (int k = 0; k < 20 && start_seq == s0; k++) step(1);
        check_eq("twait_start", (start_seq != s0), 1);
        sc = start_cyc;
        wait_tout("twait", T + 20);
        check_eq("twait_cyc", tout_cyc, sc + 1 + T);
        check_eq("twait_busy", tout_busy, 0);
        check_eq("twait_next", tout_rr, 2'b10);
        mute = 1'b0;
        drain("twait");
        m_rr = 0;

        // timeout in HOLD
        hold_stall[0] = 1'b1;
        push(0, 8'h80, 1'b0); push(0, 8'h81, 1'b1);
        push(1, 8'h90, 1'b1);
        exp_log.push_back({8'd0, 8'h80});
        exp_log.push_back({8'd1, 8'h90});
        wait_tout("thold", T + 40);
        check_eq("thold_cyc", tout_cyc, done_cyc + 1 + T);
        check_eq("thold_busy", tout_busy, 0);
        check_eq("thold_next", tout_rr, 2'b10);
        flush_seq++;
        hold_stall[0] = 1'b0;
        drain("thold");
        m_rr = 0;

        // spurious tx_done in IDLE
        man_seq++;
        step(3);
        check_eq("spur_idle_busy", busy, 0);
        check_eq("spur_idle_ready", bus.req_ready, 0);
        check_eq("spur_idle_tx", tx_log.size(), 0);

        // spurious tx_done in SEND
        mute = 1'b1;
        push(0, 8'hC0, 1'b0); push(0, 8'hC1, 1'b1);
        build_expect();
        a0 = acc_seq;
        for (int k = 0; k < 10 && acc_seq == a0; k++) step(1);
        check_eq("spur_acc", (acc_seq != a0), 1);
        man_seq++;
        for (int k = 0; k < 4; k++) begin
            step(1);
            check_eq("spur_send_busy", busy, 1);
            check_eq("spur_send_ready", bus.req_ready, 0);
        end
        mute = 1'b0;
        man_seq++;
        drain("spur");

        // reset in WAIT of a multi-byte packet
        mute = 1'b1;
        push(0, 8'hD0, 1'b0); push(0, 8'hD1, 1'b1);
        s0 = start_seq;
        for (int k = 0; k < 20 && start_seq == s0; k++) step(1);
        check_eq("mrst_start", (start_seq != s0), 1);
        step(2);
        check_eq("mrst_pre_busy", busy, 1);
        rst = 1'b0;
        #1;
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_start0", bus.tx_start, 0);
        check_eq("mrst_ready", bus.req_ready, 0);
        check_eq("mrst_data", bus.tx_data, 0);
        check_eq("mrst_grant", grant_id, 0);
        check_eq("mrst_tout", timeout_err, 0);
        flush_seq++;
        step(2);
        tx_log.delete();
        exp_log.delete();
        mute = 1'b0;
        rst = 1'b1;
        m_rr = 0;
        push(1, 8'h5A, 1'b1);
        push(0, 8'hE0, 1'b1);
        build_expect();
        drain("mrst");

        // randomized packets with random mid-packet stalls and UART delays
        rnd_stall = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                np = $urandom_range(2, 5);
                for (int p = 0; p < np; p++) begin
                    nb = $urandom_range(1, 4);
                    for (int b = 0; b < nb; b++) push(i, 8'($urandom), (b == nb - 1));
                end
            end
            build_expect();
            drain("rnd");
        end
        rnd_stall = 1'b0;

        seen = (tout_seq == 2);
        check_eq("tout_total", seen, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
